// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline it steers.
// master = controller side, slave = pipeline/fetch side.
interface pipeline_ctrl_if;
    logic        mem_busy_i;
    logic        ex_busy_i;
    logic        ld_use_i;
    logic        redirect_i;
    logic        trap_i;
    logic        fetch_req_i;
    logic        fetch_rsp_i;
    logic [3:0]  hold_o;
    logic [3:0]  clear_o;
    logic        pc_hold_o;
    logic        pc_load_o;
    logic        ex_kill_o;
    logic        fetch_kill_o;
    logic [31:0] stall_cyc_o;
    logic [31:0] flush_cnt_o;

    modport master (
        input  mem_busy_i, ex_busy_i, ld_use_i, redirect_i, trap_i,
        input  fetch_req_i, fetch_rsp_i,
        output hold_o, clear_o, pc_hold_o, pc_load_o, ex_kill_o,
        output fetch_kill_o, stall_cyc_o, flush_cnt_o
    );

    modport slave (
        output mem_busy_i, ex_busy_i, ld_use_i, redirect_i, trap_i,
        output fetch_req_i, fetch_rsp_i,
        input  hold_o, clear_o, pc_hold_o, pc_load_o, ex_kill_o,
        input  fetch_kill_o, stall_cyc_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/flush controller: pipeline register hold/clear, PC control and
// wrong-path fetch discard. Optional perf counters under PIPE_PERF_EN.
module pipeline_ctrl #(
    parameter int MAX_OUT = 2
) (
    input logic             clk,
    input logic             rst,
    pipeline_ctrl_if.master bus
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {RUN, KILL} state_e;

    logic [3:0]    hold;
    logic [3:0]    clear;
    logic          pc_hold;
    logic          pc_load;
    logic          ex_kill;
    logic [CW-1:0] out_cnt_q;
    logic [CW-1:0] out_cnt_d;
    logic [CW-1:0] kill_cnt_q;
    logic [CW-1:0] kill_cnt_d;
    state_e        state_q;

    // Priority decode of stall/flush sources; reset clears every register.
    always_comb begin
        hold    = 4'b0000;
        clear   = 4'b0000;
        pc_hold = 1'b0;
        pc_load = 1'b0;
        ex_kill = 1'b0;
        if (rst) begin
            clear = 4'b1111;
        end else begin
            priority case (1'b1)
                bus.mem_busy_i: begin
                    pc_hold = 1'b1;
                    hold    = 4'b0111;
                    clear   = 4'b1000;
                end
                bus.trap_i: begin
                    pc_load = 1'b1;
                    clear   = 4'b0111;
                    ex_kill = 1'b1;
                end
                bus.ex_busy_i: begin
                    pc_hold = 1'b1;
                    hold    = 4'b0011;
                    clear   = 4'b0100;
                end
                bus.redirect_i: begin
                    pc_load = 1'b1;
                    clear   = 4'b0011;
                end
                bus.ld_use_i: begin
                    pc_hold = 1'b1;
                    hold    = 4'b0001;
                    clear   = 4'b0010;
                end
                default: begin
                    hold = 4'b0000;
                end
            endcase
        end
    end

    // In-flight total after this cycle; a flush marks all of it wrong-path.
    always_comb begin
        out_cnt_d = out_cnt_q + CW'(bus.fetch_req_i) - CW'(bus.fetch_rsp_i);
        kill_cnt_d = kill_cnt_q;
        if (pc_load) begin
            kill_cnt_d = out_cnt_d;
        end else if (bus.fetch_rsp_i && kill_cnt_q != '0) begin
            kill_cnt_d = kill_cnt_q - CW'(1);
        end
    end

    // Fetch tracking and RUN/KILL state with registered kill output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q  <= '0;
            kill_cnt_q <= '0;
            state_q    <= RUN;
        end else begin
            out_cnt_q  <= out_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            state_q    <= (kill_cnt_d != '0) ? KILL : RUN;
        end
    end

    assign bus.hold_o       = hold;
    assign bus.clear_o      = clear;
    assign bus.pc_hold_o    = pc_hold;
    assign bus.pc_load_o    = pc_load;
    assign bus.ex_kill_o    = ex_kill;
    assign bus.fetch_kill_o = (state_q == KILL);

`ifdef PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Every stall row holds the PC and every flush row loads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (pc_hold) stall_q <= stall_q + 32'd1;
            if (pc_load) flush_q <= flush_q + 32'd1;
        end
    end

    assign bus.stall_cyc_o = stall_q;
    assign bus.flush_cnt_o = flush_q;
`else
    assign bus.stall_cyc_o = 32'd0;
    assign bus.flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MAX_OUT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  h;
        logic [3:0]  c;
        logic        ph;
        logic        pl;
        logic        ek;
        int          fk;
        bit          chkp;
        logic [31:0] s;
        logic [31:0] f;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          n_push = 0;
    int          tb_out = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_flush = 0;

    // fk: 0/1 checked, -1 fetch_kill unchecked, -2 fetch_kill and perf unchecked
    task automatic step(input logic r, mb, tr, eb, rd, lu, rq, rs,
                        input logic [3:0] h, c, input logic ph, pl, ek,
                        input int fk, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.mem_busy_i  = mb;
        bus.trap_i      = tr;
        bus.ex_busy_i   = eb;
        bus.redirect_i  = rd;
        bus.ld_use_i    = lu;
        bus.fetch_req_i = rq;
        bus.fetch_rsp_i = rs;
        if (!r && ((rq && !rs && tb_out == 2) || (rs && !rq && tb_out == 0))) begin
            n_chk++;
            n_fail++;
            $display("FAIL protocol %s: out=%0d req=%0b rsp=%0b", nm, tb_out, rq, rs);
        end
        tb_out = r ? 0 : tb_out + int'(rq) - int'(rs);
        e.h = h; e.c = c; e.ph = ph; e.pl = pl; e.ek = ek;
        e.fk = fk;
        e.chkp = (fk != -2);
`ifdef PIPE_PERF_EN
        e.s = exp_stall;
        e.f = exp_flush;
`else
        e.s = 32'd0;
        e.f = 32'd0;
`endif
        e.nm = nm;
        sb.push_back(e);
        n_push++;
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (ph) exp_stall = exp_stall + 1;
            if (pl) exp_flush = exp_flush + 1;
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            bit   bad;
            e = sb.pop_front();
            n_pop++;
            n_chk++;
            bad = (bus.hold_o !== e.h) || (bus.clear_o !== e.c) ||
                  (bus.pc_hold_o !== e.ph) || (bus.pc_load_o !== e.pl) ||
                  (bus.ex_kill_o !== e.ek);
            if (e.fk >= 0 && bus.fetch_kill_o !== e.fk[0]) bad = 1;
            if (e.chkp && (bus.stall_cyc_o !== e.s || bus.flush_cnt_o !== e.f)) bad = 1;
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got h=%b c=%b ph=%b pl=%b ek=%b fk=%b s=%0d f=%0d; want h=%b c=%b ph=%b pl=%b ek=%b fk=%0d s=%0d f=%0d",
                         e.nm, bus.hold_o, bus.clear_o, bus.pc_hold_o,
                         bus.pc_load_o, bus.ex_kill_o, bus.fetch_kill_o,
                         bus.stall_cyc_o, bus.flush_cnt_o, e.h, e.c, e.ph,
                         e.pl, e.ek, e.fk, e.s, e.f);
            end
        end
    end

    initial begin
        bus.mem_busy_i  = 1'b0;
        bus.trap_i      = 1'b0;
        bus.ex_busy_i   = 1'b0;
        bus.redirect_i  = 1'b0;
        bus.ld_use_i    = 1'b0;
        bus.fetch_req_i = 1'b0;
        bus.fetch_rsp_i = 1'b0;
        //    r mb tr eb rd lu rq rs  hold     clear    ph pl ek fk
        step(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, -2, "rst0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, "rst1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "idle");
        step(0, 0, 0, 0, 0, 1, 0, 0, 4'b0001, 4'b0010, 1, 0, 0, 0, "lduse");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "lduse_after");
        step(0, 1, 1, 0, 0, 0, 0, 0, 4'b0111, 4'b1000, 1, 0, 0, 0, "memtrap1");
        step(0, 1, 1, 0, 0, 0, 0, 0, 4'b0111, 4'b1000, 1, 0, 0, 0, "memtrap2");
        step(0, 1, 1, 0, 0, 0, 0, 0, 4'b0111, 4'b1000, 1, 0, 0, 0, "memtrap3");
        step(0, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0111, 0, 1, 1, 0, "trap_taken");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "trap_after");
        step(0, 0, 0, 1, 0, 0, 0, 0, 4'b0011, 4'b0100, 1, 0, 0, 0, "exbusy");
        step(0, 0, 0, 1, 0, 1, 0, 0, 4'b0011, 4'b0100, 1, 0, 0, 0, "exbusy_lduse");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_a");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_b");
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 0, 0, "redir2");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, "kill_rsp1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, "kill_gap");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, "kill_rsp2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "kill_done");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_c");
        step(0, 0, 0, 0, 1, 0, 1, 1, 4'b0000, 4'b0011, 0, 1, 0, 0, "redir_reqrsp");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, "kill1_rsp");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "kill1_done");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_d");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_e");
        step(0, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0111, 0, 1, 1, 0, "trap_vs_redir");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, "tk_rsp");
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 0, 1, "reflush");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, "reflush_hold");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, "reflush_rsp");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "reflush_done");
        step(0, 1, 0, 0, 1, 0, 0, 0, 4'b0111, 4'b1000, 1, 0, 0, 0, "mem_blocks_redir");
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 0, 0, "redir_late");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_f");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_g");
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 0, 0, "redir_pre_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, "kill_pre_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0, 0, -1, "rst_mid_kill");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "post_rst");
        step(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0011, 0, 1, 0, 0, "redir_out0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "out0_nokill");
        step(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "req_h");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, "rsp_h");
        step(0, 1, 1, 1, 0, 1, 0, 0, 4'b0111, 4'b1000, 1, 0, 0, 0, "all_sources");
        step(0, 0, 1, 1, 0, 1, 0, 0, 4'b0000, 4'b0111, 0, 1, 1, 0, "trap_vs_ex");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "final_idle");
        step(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, "perf_final");
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL drain: got %0d popped, %0d left; want %0d popped, 0 left",
                     n_pop, sb.size(), n_push);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
